// File: rtl/mealy_tracker.sv
// mealy_tracker: receiving-end golden model of the 8-state Mealy sequencer.
// Predicts the sequencer state from its consumed input bit, compares the
// produced output against the expected one and keeps saturating error/step
// counters plus a sticky error flag.
module mealy_tracker #(
  parameter int unsigned COUNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               smp_valid,
  input  logic               a_in,
  input  logic [1:0]         b_out,
  input  logic               resync,
  input  logic [2:0]         st_obs,
  output logic [2:0]         st_pred,
  output logic [1:0]         exp_out,
  output logic               mismatch,
  output logic               err_sticky,
  output logic [COUNT_W-1:0] err_count,
  output logic [COUNT_W-1:0] step_count,
  output logic               trapped
);

  typedef enum logic [2:0] {
    S0 = 3'd0, S1 = 3'd1, S2 = 3'd2, S3 = 3'd3,
    S4 = 3'd4, S5 = 3'd5, S6 = 3'd6, S7 = 3'd7
  } state_t;

  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  state_t             state_q;
  state_t             state_d;
  logic [1:0]         exp_out_q;
  logic [1:0]         exp_d;
  logic               mismatch_q;
  logic               err_sticky_q;
  logic [COUNT_W-1:0] err_count_q;
  logic [COUNT_W-1:0] step_count_q;

  // Golden transition/output function of the sequencer
  always_comb begin
    state_d = state_q;
    exp_d   = 2'b00;
    case (state_q)
      S0: begin
        state_d = a_in ? S2 : S4;
        exp_d   = 2'b01;
      end
      S1: begin
        state_d = S1;
        exp_d   = 2'b00;
      end
      S2: begin
        state_d = a_in ? S7 : S2;
        exp_d   = 2'b01;
      end
      S3: begin
        state_d = a_in ? S2 : S3;
        exp_d   = 2'b01;
      end
      S4: begin
        state_d = a_in ? S1 : S6;
        exp_d   = a_in ? 2'b00 : 2'b10;
      end
      S5: begin
        state_d = S7;
        exp_d   = 2'b01;
      end
      S6: begin
        state_d = S5;
        exp_d   = 2'b11;
      end
      S7: begin
        state_d = a_in ? S3 : S5;
        exp_d   = a_in ? 2'b01 : 2'b11;
      end
      default: begin
        state_d = S0;
        exp_d   = 2'b00;
      end
    endcase
  end

  // Prediction, comparison and counters; resync overrides a same-cycle step
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S0;
      exp_out_q    <= 2'b00;
      mismatch_q   <= 1'b0;
      err_sticky_q <= 1'b0;
      err_count_q  <= '0;
      step_count_q <= '0;
    end else if (resync) begin
      state_q    <= state_t'(st_obs);
      mismatch_q <= 1'b0;
    end else if (smp_valid) begin
      state_q    <= state_d;
      exp_out_q  <= exp_d;
      mismatch_q <= (b_out != exp_d);
      if (step_count_q != CNT_MAX) begin
        step_count_q <= step_count_q + COUNT_W'(1);
      end
      if (b_out != exp_d) begin
        err_sticky_q <= 1'b1;
        if (err_count_q != CNT_MAX) begin
          err_count_q <= err_count_q + COUNT_W'(1);
        end
      end
    end else begin
      mismatch_q <= 1'b0;
    end
  end

  assign st_pred    = state_q;
  assign exp_out    = exp_out_q;
  assign mismatch   = mismatch_q;
  assign err_sticky = err_sticky_q;
  assign err_count  = err_count_q;
  assign step_count = step_count_q;
  assign trapped    = (state_q == S1);

endmodule

// File: tb/tb_mealy_tracker.sv
// Directed bench for mealy_tracker: driver pushes hand-computed expectations,
// monitor pops one entry after each clock edge that follows a driven cycle.
module tb_mealy_tracker;

  logic       clk = 1'b0;
  logic       reset;
  logic       smp_valid;
  logic       a_in;
  logic [1:0] b_out;
  logic       resync;
  logic [2:0] st_obs;

  logic [2:0] st_pred,  st_pred2;
  logic [1:0] exp_out,  exp_out2;
  logic       mismatch, mismatch2;
  logic       err_sticky, err_sticky2;
  logic [7:0] err_count, step_count;
  logic [1:0] err_count2, step_count2;
  logic       trapped, trapped2;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [2:0] st;
    logic [1:0] eo;
    logic       mm;
    logic       es;
    logic [7:0] ec;
    logic [7:0] sc;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  mealy_tracker #(.COUNT_W(8)) dut (
    .clk(clk), .reset(reset), .smp_valid(smp_valid), .a_in(a_in),
    .b_out(b_out), .resync(resync), .st_obs(st_obs),
    .st_pred(st_pred), .exp_out(exp_out), .mismatch(mismatch),
    .err_sticky(err_sticky), .err_count(err_count),
    .step_count(step_count), .trapped(trapped)
  );

  mealy_tracker #(.COUNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .smp_valid(smp_valid), .a_in(a_in),
    .b_out(b_out), .resync(resync), .st_obs(st_obs),
    .st_pred(st_pred2), .exp_out(exp_out2), .mismatch(mismatch2),
    .err_sticky(err_sticky2), .err_count(err_count2),
    .step_count(step_count2), .trapped(trapped2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [1:0] sat2(input logic [7:0] v);
    return (v > 8'd3) ? 2'd3 : v[1:0];
  endfunction

  // Drive one cycle of inputs and queue the outputs expected after the edge
  task automatic step(input logic v, input logic rs, input logic a, input logic [1:0] b,
                      input logic [2:0] obs, input logic [2:0] st, input logic [1:0] eo,
                      input logic mm, input logic es, input logic [7:0] ec, input logic [7:0] sc);
    exp_t e;
    @(negedge clk);
    smp_valid = v; resync = rs; a_in = a; b_out = b; st_obs = obs;
    e.st = st; e.eo = eo; e.mm = mm; e.es = es; e.ec = ec; e.sc = sc;
    q.push_back(e);
  endtask

  // Assert reset between edges and check that outputs clear at once
  task automatic do_reset();
    @(negedge clk);
    smp_valid = 1'b0; resync = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rst_st_pred",    32'(st_pred),    32'd0);
    chk("rst_exp_out",    32'(exp_out),    32'd0);
    chk("rst_mismatch",   32'(mismatch),   32'd0);
    chk("rst_err_sticky", 32'(err_sticky), 32'd0);
    chk("rst_err_count",  32'(err_count),  32'd0);
    chk("rst_step_count", 32'(step_count), 32'd0);
    chk("rst_trapped",    32'(trapped),    32'd0);
    chk("rst_err_count2", 32'(err_count2), 32'd0);
    chk("rst_step_count2",32'(step_count2),32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: compare outputs one step after each queued drive
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("st_pred",     32'(st_pred),     32'(e.st));
        chk("exp_out",     32'(exp_out),     32'(e.eo));
        chk("mismatch",    32'(mismatch),    32'(e.mm));
        chk("err_sticky",  32'(err_sticky),  32'(e.es));
        chk("err_count",   32'(err_count),   32'(e.ec));
        chk("step_count",  32'(step_count),  32'(e.sc));
        chk("trapped",     32'(trapped),     32'(e.st == 3'd1));
        chk("err_count2",  32'(err_count2),  32'(sat2(e.ec)));
        chk("step_count2", 32'(step_count2), 32'(sat2(e.sc)));
        chk("st_pred2",    32'(st_pred2),    32'(e.st));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; smp_valid = 1'b0; resync = 1'b0;
    a_in = 1'b0; b_out = 2'b00; st_obs = 3'd0;
    #1;
    chk("init_st_pred",    32'(st_pred),    32'd0);
    chk("init_step_count", 32'(step_count), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Correct stream S0 -> S4 -> S6 -> S5 -> S7, then idle
    step(1, 0, 0, 2'b01, 0, 3'd4, 2'b01, 0, 0, 0, 1);
    step(1, 0, 0, 2'b10, 0, 3'd6, 2'b10, 0, 0, 0, 2);
    step(1, 0, 0, 2'b11, 0, 3'd5, 2'b11, 0, 0, 0, 3);
    step(1, 0, 0, 2'b01, 0, 3'd7, 2'b01, 0, 0, 0, 4);
    step(0, 0, 1, 2'b11, 0, 3'd7, 2'b01, 0, 0, 0, 4);

    // Trap into S1 and stay there
    do_reset();
    step(1, 0, 0, 2'b01, 0, 3'd4, 2'b01, 0, 0, 0, 1);
    step(1, 0, 1, 2'b00, 0, 3'd1, 2'b00, 0, 0, 0, 2);
    for (int i = 0; i < 10; i++)
      step(1, 0, 1'(i % 2), 2'b00, 0, 3'd1, 2'b00, 0, 0, 0, 8'(3 + i));

    // Single mismatch: pulse then clear, sticky stays
    do_reset();
    step(1, 0, 1, 2'b11, 0, 3'd2, 2'b01, 1, 1, 1, 1);
    step(0, 0, 0, 2'b00, 0, 3'd2, 2'b01, 0, 1, 1, 1);

    // Five mismatches: narrow counters saturate at 3
    do_reset();
    step(1, 0, 1, 2'b00, 0, 3'd2, 2'b01, 1, 1, 1, 1);
    step(1, 0, 0, 2'b00, 0, 3'd2, 2'b01, 1, 1, 2, 2);
    step(1, 0, 0, 2'b00, 0, 3'd2, 2'b01, 1, 1, 3, 3);
    step(1, 0, 0, 2'b00, 0, 3'd2, 2'b01, 1, 1, 4, 4);
    step(1, 0, 0, 2'b00, 0, 3'd2, 2'b01, 1, 1, 5, 5);

    // Resync beats a same-cycle step, then tracking continues from S7
    step(1, 1, 1, 2'b10, 3'd7, 3'd7, 2'b01, 0, 1, 5, 5);
    step(1, 0, 1, 2'b01, 0, 3'd3, 2'b01, 0, 1, 5, 6);
    step(0, 1, 0, 2'b00, 3'd1, 3'd1, 2'b01, 0, 1, 5, 6);
    step(1, 0, 0, 2'b00, 0, 3'd1, 2'b00, 0, 1, 5, 7);
    step(0, 1, 0, 2'b00, 3'd0, 3'd0, 2'b00, 0, 1, 5, 7);

    // Reach S6 with an error, then reset asynchronously mid-stream
    step(1, 0, 0, 2'b11, 0, 3'd4, 2'b01, 1, 1, 6, 8);
    step(1, 0, 0, 2'b10, 0, 3'd6, 2'b10, 0, 1, 6, 9);
    do_reset();
    step(1, 0, 1, 2'b01, 0, 3'd2, 2'b01, 0, 0, 0, 1);
    step(0, 0, 0, 2'b00, 0, 3'd2, 2'b01, 0, 0, 0, 1);

    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mealy_tracker.md
# mealy_tracker

Output-side companion to the team's 8-state Mealy sequencer. Consumes the sequencer's per-step (a_in, b_out) stream and runs a cycle-accurate golden model of the transition/output function. It tracks the predicted state, flags output mismatches, counts errors and reports entry into the absorbing state. It sits beside the sequencer in the datapath, or in the bench, as its receiving-end checker.

## Interface
- COUNT_W, 8: width of the error and step counters; both saturate.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- smp_valid  in  1  qualifies one sequencer step on this cycle.
- a_in  in  1  input bit the sequencer consumed on this step.
- b_out  in  2  output the sequencer produced on this step.
- resync  in  1  load the predicted state from st_obs; takes priority over smp_valid.
- st_obs  in  3  observed sequencer state, used only by resync.
- st_pred  out  3  predicted current state.
- exp_out  out  2  expected b_out of the last accepted step.
- mismatch  out  1  one-cycle pulse: last accepted step's b_out differed from expected.
- err_sticky  out  1  set on any mismatch; cleared only by reset.
- err_count  out  COUNT_W  number of mismatching steps, saturating.
- step_count  out  COUNT_W  number of accepted steps, saturating.
- trapped  out  1  high while st_pred is S1 (absorbing).

## Operation
- Golden function, listed as state: a=0 -> next/out, a=1 -> next/out:
  - S0: S4/01, S2/01
  - S1: S1/00, S1/00
  - S2: S2/01, S7/01
  - S3: S3/01, S2/01
  - S4: S6/10, S1/00
  - S5: S7/01, S7/01
  - S6: S5/11, S5/11
  - S7: S5/11, S3/01
- Accepted step (smp_valid=1, resync=0):
  - exp = out(st_pred, a_in).
  - st_pred <= next(st_pred, a_in).
  - exp_out <= exp.
  - mismatch <= (b_out != exp).
  - step_count increments.
  - On mismatch, err_count increments and err_sticky sets.
- The model advances on the fed-back a_in even on mismatch; it never self-corrects its state.
- resync=1:
  - st_pred <= st_obs.
  - No comparison is made; mismatch=0; counters are held.
  - The same cycle's smp_valid is ignored.
- Idle (smp_valid=0, resync=0): all state holds; mismatch=0.
- Counters saturate at 2^COUNT_W-1 and do not wrap. err_count saturating does not clear err_sticky.
- trapped is derived combinationally from st_pred==S1. It remains high until resync or reset.

## Timing
- Reset values:
  - st_pred=S0 (000)
  - exp_out=00
  - mismatch=0
  - err_sticky=0
  - err_count=0
  - step_count=0
  - trapped=0
- All outputs except trapped are registered.
- Latency: one clock from the accepted step to st_pred/exp_out/mismatch/counter update.
- Back-to-back steps are accepted every cycle; no backpressure.
- Reset asserted mid-stream clears everything immediately and asynchronously. The first step after reset release is evaluated from S0.
- resync with smp_valid in the same cycle: resync wins, and the step is dropped and not counted.

## Test plan
- Reset release, then a_in=0,0,0,0 with the correct b_out=01,10,11,01:
  - st_pred goes S4,S6,S5,S7.
  - err_count=0; step_count=4.
- From S0, a_in=0,1 with b_out=01,00:
  - st_pred=S1 and trapped=1.
  - A further 10 steps keep S1 with exp_out=00.
- From S0, a_in=1 with wrong b_out=11:
  - mismatch pulses 1 cycle later.
  - exp_out=01; err_sticky=1; err_count=1; st_pred=S2.
- With COUNT_W=2, feed 5 mismatching steps: err_count holds at 3 and step_count holds at 3.
- resync=1 with st_obs=S7 and smp_valid=1, a_in=1:
  - Next cycle st_pred=S7; step_count unchanged.
  - A following step with a_in=1, b_out=01 gives st_pred=S3, no mismatch.
- Assert reset while st_pred=S6 and err_sticky=1: outputs return to reset values immediately, before the next clock edge.
